uart_cmd_ctrl: RTL and testbench
================================

// Module: uart_cmd_ctrl
// PURPOSE
//  Command sequencer between uart_transceiver and dig_core's register space. Collects 3-byte host frames
//  {opcode, addr, data} from the rx side, issues one register write or read strobe, then returns one
//  response byte through the tx side. Sole owner of the transceiver tx port; handles framing timeout.
// PARAMETERS
//  TIMEOUT_CYC  1000000  max idle cycles between bytes of a frame, also max wait for reg_rvalid_i
//  OP_WR        8'hA1    opcode: register write
//  OP_RD        8'hA2    opcode: register read
//  ACK_BYTE     8'h55    response to a successful write
//  NAK_BYTE     8'hEE    response to bad opcode or read timeout
// PORTS
//  clk           in   1  system clock
//  rst_n         in   1  asynchronous active-low reset
//  rx_done_i     in   1  one-cycle pulse; rx_data_i valid in that cycle
//  rx_data_i     in   8  received byte
//  tx_wr_o       out  1  one-cycle pulse starting a transmit
//  tx_data_o     out  8  byte to transmit; held stable from tx_wr_o until tx_done_i
//  tx_done_i     in   1  one-cycle pulse, transmit finished
//  reg_wr_o      out  1  one-cycle register write strobe
//  reg_rd_o      out  1  one-cycle register read strobe
//  reg_addr_o    out  8  register address, valid with either strobe and held until IDLE
//  reg_wdata_o   out  8  write data, valid with reg_wr_o
//  reg_rdata_i   in   8  read data, sampled when reg_rvalid_i=1
//  reg_rvalid_i  in   1  read data valid; accepted same cycle as reg_rd_o or later
//  busy_o        out  1  1 in every state except IDLE
//  err_o         out  1  sticky error flag; cleared only by reset
//  frame_cnt_o   out  8  count of successful frames (ACK or read data sent), wraps 255->0
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, timeout counter 0; takes effect mid-frame/mid-tx, partial frame discarded.
//  States: IDLE -> GET_ADDR -> GET_DATA -> EXEC -> [WAIT_RD] -> TX_START -> TX_WAIT -> IDLE.
//  IDLE: rx_done_i latches opcode -> GET_ADDR. GET_ADDR: rx_done_i latches addr -> GET_DATA.
//  GET_DATA: rx_done_i latches data -> EXEC. Opcode checked only in EXEC (frame always 3 bytes).
//  Timeout: counter clears on each accepted byte, increments each cycle in GET_ADDR/GET_DATA;
//   reaching TIMEOUT_CYC -> IDLE, err_o=1, no response. rx_done_i in the expiry cycle wins: byte accepted.
//  EXEC (1 cycle): OP_WR -> reg_wr_o=1, resp=ACK_BYTE -> TX_START. OP_RD -> reg_rd_o=1 -> WAIT_RD.
//   other opcode -> no strobe, resp=NAK_BYTE, err_o=1 -> TX_START.
//  WAIT_RD: reg_rvalid_i=1 (also honoured in the EXEC cycle) -> resp=reg_rdata_i -> TX_START;
//   TIMEOUT_CYC cycles without it -> resp=NAK_BYTE, err_o=1 -> TX_START.
//  TX_START (1 cycle): tx_wr_o=1, tx_data_o=resp -> TX_WAIT. TX_WAIT: tx_done_i -> IDLE,
//   frame_cnt_o+1 unless resp was NAK. No timeout in TX_WAIT.
//  Latency write: 3rd rx_done_i at cycle N -> reg_wr_o N+1 -> tx_wr_o N+2.
//  Latency read: reg_rvalid_i at cycle M (M>=N+1) -> tx_wr_o M+1.
//  Overrun: rx_done_i in EXEC/WAIT_RD/TX_START/TX_WAIT -> byte dropped, err_o=1, state unaffected.
//  tx_done_i outside TX_WAIT and reg_rvalid_i outside EXEC/WAIT_RD are ignored.
//  Strobes never overlap; at most one reg strobe and one tx_wr_o per frame.
// TESTING (bench: divisor 326, 50 MHz clk, TIMEOUT_CYC=2000 for timeout cases)
//  1 send A1 00 01 -> one reg_wr_o with addr 00 wdata 01; host receives 55; frame_cnt_o=1; err_o=0.
//  2 send A2 07 00, reg model returns 3C two cycles after reg_rd_o -> one reg_rd_o addr 07;
//    host receives 3C.
//  3 send 7F 00 01 -> no reg strobe; host receives EE; err_o=1; frame_cnt_o unchanged.
//  4 send A1, idle 2000+ cycles -> back to IDLE, busy_o=0, err_o=1, no tx; then A1 02 09 -> write, 55.
//  5 A2 read with reg_rvalid_i never asserted -> EE after TIMEOUT_CYC; extra byte sent during TX_WAIT
//    is dropped, next frame decodes correctly.
//  6 reset asserted after 2nd byte and during TX_WAIT -> all outputs 0 immediately; 256 good frames
//    -> frame_cnt_o wraps to 0.

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
// Host command sequencer: gathers {opcode, addr, data} frames from the UART receiver,
// issues one register strobe, and answers with a single response byte on the transmitter.
module uart_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter logic [7:0]  OP_WR       = 8'hA1,
  parameter logic [7:0]  OP_RD       = 8'hA2,
  parameter logic [7:0]  ACK_BYTE    = 8'h55,
  parameter logic [7:0]  NAK_BYTE    = 8'hEE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_done_i,
  input  logic [7:0] rx_data_i,
  output logic       tx_wr_o,
  output logic [7:0] tx_data_o,
  input  logic       tx_done_i,
  output logic       reg_wr_o,
  output logic       reg_rd_o,
  output logic [7:0] reg_addr_o,
  output logic [7:0] reg_wdata_o,
  input  logic [7:0] reg_rdata_i,
  input  logic       reg_rvalid_i,
  output logic       busy_o,
  output logic       err_o,
  output logic [7:0] frame_cnt_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_DATA, EXEC, WAIT_RD, TX_START, TX_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic [7:0]    op_q, op_d;
  logic          nak_q, nak_d;
  logic          tx_wr_q, tx_wr_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          reg_wr_q, reg_wr_d;
  logic          reg_rd_q, reg_rd_d;
  logic [7:0]    reg_addr_q, reg_addr_d;
  logic [7:0]    reg_wdata_q, reg_wdata_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;

  logic          send;
  logic          resp_nak;
  logic [7:0]    resp;

  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    op_d        = op_q;
    nak_d       = nak_q;
    tx_wr_d     = 1'b0;
    tx_data_d   = tx_data_q;
    reg_wr_d    = 1'b0;
    reg_rd_d    = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    err_d       = err_q;
    frame_cnt_d = frame_cnt_q;
    send        = 1'b0;
    resp_nak    = 1'b0;
    resp        = NAK_BYTE;

    case (state_q)
      IDLE: begin
        if (rx_done_i) begin
          op_d    = rx_data_i;
          tmo_d   = '0;
          state_d = GET_ADDR;
        end
      end
      GET_ADDR, GET_DATA: begin
        // An arriving byte takes priority over an expiring timeout.
        if (rx_done_i) begin
          tmo_d = '0;
          if (state_q == GET_ADDR) begin
            reg_addr_d = rx_data_i;
            state_d    = GET_DATA;
          end else begin
            reg_wdata_d = rx_data_i;
            state_d     = EXEC;
            // Strobes are registered, so they are decided on the way into EXEC.
            reg_wr_d    = (op_q == OP_WR);
            reg_rd_d    = (op_q == OP_RD);
          end
        end else if (tmo_q == TMO_LAST) begin
          tmo_d   = '0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      EXEC: begin
        if (op_q == OP_WR) begin
          send = 1'b1;
          resp = ACK_BYTE;
        end else if (op_q == OP_RD) begin
          if (reg_rvalid_i) begin
            send = 1'b1;
            resp = reg_rdata_i;
          end else begin
            state_d = WAIT_RD;
          end
        end else begin
          send     = 1'b1;
          resp_nak = 1'b1;
        end
      end
      WAIT_RD: begin
        if (reg_rvalid_i) begin
          send = 1'b1;
          resp = reg_rdata_i;
        end else if (tmo_q == TMO_LAST) begin
          tmo_d    = '0;
          send     = 1'b1;
          resp_nak = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      TX_START: state_d = TX_WAIT;
      TX_WAIT: begin
        if (tx_done_i) begin
          state_d = IDLE;
          if (!nak_q) frame_cnt_d = frame_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (send) begin
      tx_wr_d   = 1'b1;
      tx_data_d = resp;
      nak_d     = resp_nak;
      state_d   = TX_START;
      if (resp_nak) err_d = 1'b1;
    end

    // Bytes arriving while a frame is being executed or answered are lost.
    if (rx_done_i && (state_q inside {EXEC, WAIT_RD, TX_START, TX_WAIT})) err_d = 1'b1;

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tmo_q       <= '0;
      op_q        <= '0;
      nak_q       <= 1'b0;
      tx_wr_q     <= 1'b0;
      tx_data_q   <= '0;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      op_q        <= op_d;
      nak_q       <= nak_d;
      tx_wr_q     <= tx_wr_d;
      tx_data_q   <= tx_data_d;
      reg_wr_q    <= reg_wr_d;
      reg_rd_q    <= reg_rd_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign tx_wr_o     = tx_wr_q;
  assign tx_data_o   = tx_data_q;
  assign reg_wr_o    = reg_wr_q;
  assign reg_rd_o    = reg_rd_q;
  assign reg_addr_o  = reg_addr_q;
  assign reg_wdata_o = reg_wdata_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: byte-level host frames, a register responder and
// a transmitter responder driven from tasks, checked against a frame-level reference model.
module tb_uart_cmd_ctrl;

  localparam int TMO = 2000;
  localparam logic [7:0] OPW = 8'hA1;
  localparam logic [7:0] OPR = 8'hA2;
  localparam logic [7:0] ACK = 8'h55;
  localparam logic [7:0] NAK = 8'hEE;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_done_i = 1'b0;
  logic [7:0] rx_data_i = '0;
  logic       tx_wr_o;
  logic [7:0] tx_data_o;
  logic       tx_done_i = 1'b0;
  logic       reg_wr_o, reg_rd_o;
  logic [7:0] reg_addr_o, reg_wdata_o;
  logic [7:0] reg_rdata_i = '0;
  logic       reg_rvalid_i = 1'b0;
  logic       busy_o, err_o;
  logic [7:0] frame_cnt_o;

  uart_cmd_ctrl #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_done_i(rx_done_i), .rx_data_i(rx_data_i),
    .tx_wr_o(tx_wr_o), .tx_data_o(tx_data_o), .tx_done_i(tx_done_i),
    .reg_wr_o(reg_wr_o), .reg_rd_o(reg_rd_o),
    .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o),
    .reg_rdata_i(reg_rdata_i), .reg_rvalid_i(reg_rvalid_i),
    .busy_o(busy_o), .err_o(err_o), .frame_cnt_o(frame_cnt_o)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed strobe activity, sampled mid-cycle.
  int wr_cnt = 0, rd_cnt = 0, tx_cnt = 0, overlap_cnt = 0;
  int wr_cyc = 0, rd_cyc = 0, tx_cyc = 0;
  logic [7:0] wr_addr = '0, wr_data = '0, rd_addr = '0, tx_byte = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_wr_o) begin
        wr_cnt <= wr_cnt + 1; wr_addr <= reg_addr_o; wr_data <= reg_wdata_o; wr_cyc <= cyc;
      end
      if (reg_rd_o) begin
        rd_cnt <= rd_cnt + 1; rd_addr <= reg_addr_o; rd_cyc <= cyc;
      end
      if (tx_wr_o) begin
        tx_cnt <= tx_cnt + 1; tx_byte <= tx_data_o; tx_cyc <= cyc;
      end
      if (int'(reg_wr_o) + int'(reg_rd_o) + int'(tx_wr_o) > 1) overlap_cnt <= overlap_cnt + 1;
    end
  end

  int n_checks = 0, n_pass = 0;

  // Reference model state: good-frame count and sticky error.
  int m_cnt = 0;
  bit m_err = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data_i = b;
    rx_done_i = 1'b1;
    step();
    rx_done_i = 1'b0;
  endtask

  task automatic check_outs_zero(input string name);
    check(name, {tx_wr_o, tx_data_o, reg_wr_o, reg_rd_o, reg_addr_o, reg_wdata_o,
                 busy_o, err_o, frame_cnt_o}, 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check_outs_zero("reset_immediate");
    step(); step();
    rst_n = 1'b1;
    step();
    m_cnt = 0;
    m_err = 1'b0;
  endtask

  // Expected frame outcome derived directly from the opcode rules.
  function automatic void predict(input logic [7:0] op, input logic [7:0] rdata, input int rd_delay,
                                  output logic [7:0] resp, output bit wr, output bit rd);
    wr = (op == OPW);
    rd = (op == OPR);
    if (wr) resp = ACK;
    else if (rd && rd_delay >= 0) resp = rdata;
    else resp = NAK;
  endfunction

  task automatic run_frame(input logic [7:0] op, input logic [7:0] addr, input logic [7:0] data,
                           input logic [7:0] rdata, input int rd_delay, input int tx_delay,
                           input bit overrun, input logic [7:0] exp_resp,
                           input bit exp_wr, input bit exp_rd);
    int wr0, rd0, tx0, n, lim;
    bit hold_bad, rd_to;
    wr0 = wr_cnt; rd0 = rd_cnt; tx0 = tx_cnt;
    rd_to = exp_rd && (rd_delay < 0);
    hold_bad = 1'b0;

    send_byte(op);
    repeat ($urandom_range(0, 3)) step();
    send_byte(addr);
    repeat ($urandom_range(0, 3)) step();
    n = cyc;
    send_byte(data);

    if (exp_rd && rd_delay >= 0) begin
      while (cyc < n + 1 + rd_delay) step();
      reg_rvalid_i = 1'b1;
      reg_rdata_i  = rdata;
      step();
      reg_rvalid_i = 1'b0;
      reg_rdata_i  = 8'($urandom);
    end

    lim = 0;
    while (tx_cnt == tx0 && lim < 2 * TMO + 50) begin
      step();
      lim++;
    end
    if (tx_cnt == tx0) begin
      check("tx_seen", 0, 1);
      return;
    end
    check("tx_byte", tx_byte, exp_resp);
    if (rd_to) check("rd_timeout_window", (tx_cyc >= n + TMO) && (tx_cyc <= n + TMO + 4), 1);
    else if (exp_rd) check("rd_tx_latency", tx_cyc - n, 2 + rd_delay);
    else check("tx_latency", tx_cyc - n, 2);

    for (int k = 0; k < tx_delay; k++) begin
      if (overrun && k == tx_delay / 2) begin
        rx_data_i = OPW;
        rx_done_i = 1'b1;
      end
      step();
      rx_done_i = 1'b0;
      if (tx_data_o != exp_resp) hold_bad = 1'b1;
    end
    tx_done_i = 1'b1;
    step();
    tx_done_i = 1'b0;
    step();

    if (exp_resp != NAK) m_cnt = (m_cnt + 1) % 256;
    if (exp_resp == NAK || overrun) m_err = 1'b1;

    check("wr_pulses", wr_cnt - wr0, int'(exp_wr));
    check("rd_pulses", rd_cnt - rd0, int'(exp_rd));
    check("tx_pulses", tx_cnt - tx0, 1);
    if (exp_wr) begin
      check("wr_addr", wr_addr, addr);
      check("wr_data", wr_data, data);
      check("wr_latency", wr_cyc - n, 1);
    end
    if (exp_rd) begin
      check("rd_addr", rd_addr, addr);
      check("rd_latency", rd_cyc - n, 1);
    end
    check("tx_data_hold", hold_bad, 0);
    check("busy_idle", busy_o, 0);
    check("frame_cnt", frame_cnt_o, m_cnt);
    check("err", err_o, m_err);
    $display("frame op=%02h addr=%02h data=%02h -> tx=%02h cnt=%0d err=%0b",
             op, addr, data, tx_byte, frame_cnt_o, err_o);
  endtask

  typedef struct {
    logic [7:0] op, addr, data, rdata;
    int         rd_delay, tx_delay;
    bit         overrun;
    logic [7:0] exp_resp;
    bit         exp_wr, exp_rd;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [7:0] op, rdata, resp;
    bit wr, rd;
    int lim, tx0, wr0, rd0;

    tbl[0] = '{8'hA1, 8'h00, 8'h01, 8'h00,  0, 3, 1'b0, 8'h55, 1'b1, 1'b0};
    tbl[1] = '{8'hA2, 8'h07, 8'h00, 8'h3C,  2, 3, 1'b0, 8'h3C, 1'b0, 1'b1};
    tbl[2] = '{8'hA2, 8'h10, 8'h00, 8'h99,  0, 2, 1'b0, 8'h99, 1'b0, 1'b1};
    tbl[3] = '{8'hA1, 8'hFF, 8'hAA, 8'h00,  0, 5, 1'b0, 8'h55, 1'b1, 1'b0};
    tbl[4] = '{8'hA2, 8'h33, 8'h00, 8'h00,  5, 2, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[5] = '{8'h7F, 8'h00, 8'h01, 8'h00,  0, 3, 1'b0, 8'hEE, 1'b0, 1'b0};
    tbl[6] = '{8'hA2, 8'h44, 8'h00, 8'h12, -1, 4, 1'b1, 8'hEE, 1'b0, 1'b1};
    tbl[7] = '{8'hA1, 8'h0C, 8'h0D, 8'h00,  0, 2, 1'b0, 8'h55, 1'b1, 1'b0};
    tbl[8] = '{8'hA0, 8'h01, 8'h02, 8'h00,  0, 2, 1'b0, 8'hEE, 1'b0, 1'b0};

    // Power-on reset.
    repeat (3) step();
    check_outs_zero("reset_state");
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 9; i++)
      run_frame(tbl[i].op, tbl[i].addr, tbl[i].data, tbl[i].rdata, tbl[i].rd_delay,
                tbl[i].tx_delay, tbl[i].overrun, tbl[i].exp_resp, tbl[i].exp_wr, tbl[i].exp_rd);

    // Reset after the second byte discards the partial frame.
    send_byte(OPW);
    send_byte(8'h05);
    apply_reset();
    run_frame(OPW, 8'h02, 8'h09, 8'h00, 0, 2, 1'b0, ACK, 1'b1, 1'b0);

    // Reset while waiting for the transmitter to finish.
    tx0 = tx_cnt;
    send_byte(OPW); send_byte(8'h0A); send_byte(8'h0B);
    lim = 0;
    while (tx_cnt == tx0 && lim < 20) begin step(); lim++; end
    check("txwait_tx_seen", tx_cnt - tx0, 1);
    step();
    apply_reset();
    step();
    check("txwait_busy_after_reset", busy_o, 0);
    $display("reset during TX_WAIT, busy=%0b cnt=%0d", busy_o, frame_cnt_o);

    // Host stalls after the opcode: frame abandoned with error, no response.
    tx0 = tx_cnt; wr0 = wr_cnt; rd0 = rd_cnt;
    send_byte(OPW);
    repeat (TMO - 5) step();
    check("to_busy_before", busy_o, 1);
    repeat (12) step();
    check("to_busy_after", busy_o, 0);
    check("to_err", err_o, 1);
    check("to_no_activity", (tx_cnt - tx0) + (wr_cnt - wr0) + (rd_cnt - rd0), 0);
    m_err = 1'b1;
    $display("frame timeout after opcode, busy=%0b err=%0b", busy_o, err_o);
    run_frame(OPW, 8'h02, 8'h09, 8'h00, 0, 2, 1'b0, ACK, 1'b1, 1'b0);

    // Randomized frames against the reference model.
    for (int i = 0; i < 40; i++) begin
      int sel, d;
      sel = $urandom_range(0, 9);
      if (sel < 4) op = OPW;
      else if (sel < 8) op = OPR;
      else begin
        op = 8'($urandom);
        while (op == OPW || op == OPR) op = 8'($urandom);
      end
      rdata = 8'($urandom);
      while (rdata == NAK) rdata = 8'($urandom);
      d = $urandom_range(0, 6);
      predict(op, rdata, d, resp, wr, rd);
      run_frame(op, 8'($urandom), 8'($urandom), rdata, d, $urandom_range(2, 6),
                1'($urandom_range(0, 1)), resp, wr, rd);
    end

    // 256 good frames wrap the counter back to zero.
    apply_reset();
    for (int i = 0; i < 256; i++) begin
      op = ($urandom_range(0, 1) == 0) ? OPW : OPR;
      rdata = 8'($urandom);
      while (rdata == NAK) rdata = 8'($urandom);
      predict(op, rdata, 1, resp, wr, rd);
      run_frame(op, 8'($urandom), 8'($urandom), rdata, $urandom_range(0, 3), 2, 1'b0, resp, wr, rd);
      if (i == 254) check("cnt_255", frame_cnt_o, 255);
    end
    check("cnt_wrap", frame_cnt_o, 0);
    check("strobe_overlap", overlap_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
